// File: rtl/multi_port_cdb.sv
// multi_port_cdb: common data bus with per-FU collapsing completion buffers,
// NUM_CDB round-robin broadcasts per cycle and ROB-range rollback squash.
module multi_port_cdb #(
    parameter int NUM_FU    = 8,
    parameter int NUM_CDB   = 2,
    parameter int BUF_DEPTH = 2,
    parameter int ROB_W     = 5,
    parameter int PR_W      = 6,
    parameter int XLEN      = 64
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_en,
    input  logic [NUM_FU-1:0]         i_fu_done,
    input  logic [NUM_FU*PR_W-1:0]    i_fu_T_idx,
    input  logic [NUM_FU*ROB_W-1:0]   i_fu_ROB_idx,
    input  logic [NUM_FU*5-1:0]       i_fu_dest_idx,
    input  logic [NUM_FU*XLEN-1:0]    i_fu_result,
    output logic [NUM_FU-1:0]         o_fu_ready,
    input  logic                      i_rollback_en,
    input  logic [ROB_W-1:0]          i_ROB_rollback_idx,
    input  logic [ROB_W-1:0]          i_diff_ROB,
    output logic [NUM_CDB-1:0]        o_cdb_valid,
    output logic [NUM_CDB*PR_W-1:0]   o_cdb_T_idx,
    output logic [NUM_CDB*ROB_W-1:0]  o_cdb_ROB_idx,
    output logic [NUM_CDB*5-1:0]      o_cdb_dest_idx,
    output logic [NUM_CDB*XLEN-1:0]   o_cdb_value
);

    localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic                r_valid [NUM_FU][BUF_DEPTH];
    logic [PR_W-1:0]     r_t     [NUM_FU][BUF_DEPTH];
    logic [ROB_W-1:0]    r_rob   [NUM_FU][BUF_DEPTH];
    logic [4:0]          r_dest  [NUM_FU][BUF_DEPTH];
    logic [XLEN-1:0]     r_value [NUM_FU][BUF_DEPTH];
    logic [RR_W-1:0]     r_rr_ptr;

    logic                w_n_valid [NUM_FU][BUF_DEPTH];
    logic [PR_W-1:0]     w_n_t     [NUM_FU][BUF_DEPTH];
    logic [ROB_W-1:0]    w_n_rob   [NUM_FU][BUF_DEPTH];
    logic [4:0]          w_n_dest  [NUM_FU][BUF_DEPTH];
    logic [XLEN-1:0]     w_n_value [NUM_FU][BUF_DEPTH];
    logic                w_squash  [NUM_FU][BUF_DEPTH];
    logic [NUM_FU-1:0]   w_cand;
    logic [NUM_FU-1:0]   w_grant;
    logic [NUM_FU-1:0]   w_push;
    logic                w_any;
    logic [RR_W-1:0]     w_rr_next;

    // An entry is younger than the rollback point when its ROB distance is in 1..diff
    function automatic logic f_squash(input logic [ROB_W-1:0] rob,
                                      input logic             rb_en,
                                      input logic [ROB_W-1:0] base,
                                      input logic [ROB_W-1:0] span);
        logic [ROB_W-1:0] d;
        d = rob - base;
        return rb_en && (d != '0) && (d <= span);
    endfunction

    // Per-entry squash flags, arbitration candidates and FU backpressure
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = 0; j < BUF_DEPTH; j++) begin
                w_squash[i][j] = r_valid[i][j] &&
                                 f_squash(r_rob[i][j], i_rollback_en, i_ROB_rollback_idx, i_diff_ROB);
            end
            w_cand[i]     = r_valid[i][0] && !w_squash[i][0];
            o_fu_ready[i] = i_en && !r_valid[i][BUF_DEPTH-1];
        end
    end

    // Round-robin scan from rr_ptr granting up to NUM_CDB heads onto ports in scan order
    always_comb begin
        int cnt;
        int idx;
        int last;
        w_grant        = '0;
        w_any          = 1'b0;
        w_rr_next      = r_rr_ptr;
        o_cdb_valid    = '0;
        o_cdb_T_idx    = '0;
        o_cdb_ROB_idx  = '0;
        o_cdb_dest_idx = '0;
        o_cdb_value    = '0;
        cnt  = 0;
        last = 0;
        for (int off = 0; off < NUM_FU; off++) begin
            idx = int'(r_rr_ptr) + off;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (i_en && w_cand[idx] && (cnt < NUM_CDB)) begin
                w_grant[idx]                          = 1'b1;
                o_cdb_valid[cnt]                      = 1'b1;
                o_cdb_T_idx[cnt*PR_W +: PR_W]         = r_t[idx][0];
                o_cdb_ROB_idx[cnt*ROB_W +: ROB_W]     = r_rob[idx][0];
                o_cdb_dest_idx[cnt*5 +: 5]            = r_dest[idx][0];
                o_cdb_value[cnt*XLEN +: XLEN]         = r_value[idx][0];
                cnt   = cnt + 1;
                last  = idx;
                w_any = 1'b1;
            end
        end
        if (w_any) begin
            w_rr_next = (last == NUM_FU - 1) ? '0 : RR_W'(last + 1);
        end
    end

    // Compact survivors toward slot 0 in order, then append an accepted push behind them
    always_comb begin
        int n;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = 0; j < BUF_DEPTH; j++) begin
                w_n_valid[i][j] = 1'b0;
                w_n_t[i][j]     = '0;
                w_n_rob[i][j]   = '0;
                w_n_dest[i][j]  = '0;
                w_n_value[i][j] = '0;
            end
            n = 0;
            for (int j = 0; j < BUF_DEPTH; j++) begin
                if (r_valid[i][j] && !w_squash[i][j] && !((j == 0) && w_grant[i])) begin
                    if (n < BUF_DEPTH) begin
                        w_n_valid[i][n] = 1'b1;
                        w_n_t[i][n]     = r_t[i][j];
                        w_n_rob[i][n]   = r_rob[i][j];
                        w_n_dest[i][n]  = r_dest[i][j];
                        w_n_value[i][n] = r_value[i][j];
                    end
                    n = n + 1;
                end
            end
            w_push[i] = i_en && i_fu_done[i] && !r_valid[i][BUF_DEPTH-1] &&
                        !f_squash(i_fu_ROB_idx[i*ROB_W +: ROB_W], i_rollback_en,
                                  i_ROB_rollback_idx, i_diff_ROB);
            if (w_push[i] && (n < BUF_DEPTH)) begin
                w_n_valid[i][n] = 1'b1;
                w_n_t[i][n]     = i_fu_T_idx[i*PR_W +: PR_W];
                w_n_rob[i][n]   = i_fu_ROB_idx[i*ROB_W +: ROB_W];
                w_n_dest[i][n]  = i_fu_dest_idx[i*5 +: 5];
                w_n_value[i][n] = i_fu_result[i*XLEN +: XLEN];
            end
        end
    end

    // Buffer contents and round-robin pointer registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    r_valid[i][j] <= 1'b0;
                    r_t[i][j]     <= '0;
                    r_rob[i][j]   <= '0;
                    r_dest[i][j]  <= '0;
                    r_value[i][j] <= '0;
                end
            end
            r_rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    r_valid[i][j] <= w_n_valid[i][j];
                    r_t[i][j]     <= w_n_t[i][j];
                    r_rob[i][j]   <= w_n_rob[i][j];
                    r_dest[i][j]  <= w_n_dest[i][j];
                    r_value[i][j] <= w_n_value[i][j];
                end
            end
            r_rr_ptr <= w_rr_next;
        end
    end

endmodule
